// File: rtl/wash_plant.sv
// rtl/wash_plant.sv - drum and sensor responder for the wash controller
// Optional protocol checking is enabled by defining WASH_PLANT_FAULT_EN.
module wash_plant #(
    parameter int WASH_CYC    = 8,
    parameter int RINSE_CYC   = 4,
    parameter int DRY_CYC     = 6,
    parameter int LARGE_EXTRA = 4,
    parameter int WET_MAX     = 2
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       LOAD,
    input  logic       LOADSIZE,
    input  logic [2:0] SOILIN,
    input  logic       UNLOAD,
    input  logic       MEDIUMOut,
    input  logic       LARGEOut,
    input  logic       WASH,
    input  logic       RINSE,
    input  logic       DRY,
    output logic       MEDIUMIn,
    output logic       LARGEIn,
    output logic       DIRTY,
    output logic       WET,
    output logic       WDONE,
    output logic       RDONE,
    output logic       DDONE,
    output logic       FAULT
);

    typedef enum logic [1:0] {PH_NONE, PH_WASH, PH_RINSE, PH_DRY} phase_t;

    localparam logic [12:0] WASH_L   = 13'(WASH_CYC);
    localparam logic [12:0] RINSE_L  = 13'(RINSE_CYC);
    localparam logic [12:0] DRY_L    = 13'(DRY_CYC);
    localparam logic [12:0] LARGE_X  = 13'(LARGE_EXTRA);
    localparam logic [3:0]  WET_FULL = 4'(WET_MAX);

    phase_t      prev_q;
    phase_t      act;
    logic        occ_m;
    logic        occ_l;
    logic [2:0]  soil;
    logic [3:0]  wet;
    logic [11:0] timer;
    logic [11:0] tcur;
    logic [11:0] timer_nxt;
    logic        fault;
    logic        fault_now;
    logic        wdone_q;
    logic        rdone_q;
    logic        ddone_q;
    logic [1:0]  nph;
    logic        any_phase;
    logic        occupied;
    logic        done;
    logic [12:0] base;
    logic [12:0] len;

    always_comb begin
        nph       = {1'b0, WASH} + {1'b0, RINSE} + {1'b0, DRY};
        any_phase = WASH | RINSE | DRY;
        occupied  = occ_m | occ_l;
        fault_now = 1'b0;
        act       = PH_NONE;
`ifdef WASH_PLANT_FAULT_EN
        fault_now = (nph > 2'd1) || (any_phase && !occupied) ||
                    (MEDIUMOut && LARGEOut) ||
                    (occupied && ((MEDIUMOut && !occ_m) || (LARGEOut && !occ_l)));
        if (nph == 2'd1 && !fault && !fault_now) begin
            act = WASH ? PH_WASH : (RINSE ? PH_RINSE : PH_DRY);
        end
`else
        if (WASH) begin
            act = PH_WASH;
        end else if (RINSE) begin
            act = PH_RINSE;
        end else if (DRY) begin
            act = PH_DRY;
        end
`endif
        case (act)
            PH_WASH:  base = WASH_L;
            PH_RINSE: base = RINSE_L;
            PH_DRY:   base = DRY_L;
            default:  base = 13'd1;
        endcase
        len = base + (occ_l ? LARGE_X : 13'd0);
        // A phase change counts this edge as the first edge of the new phase.
        tcur      = (act == prev_q) ? timer : 12'd0;
        done      = (act != PH_NONE) && ({1'b0, tcur} == len - 13'd1);
        timer_nxt = (act == PH_NONE || done) ? 12'd0 : tcur + 12'd1;
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            prev_q  <= PH_NONE;
            occ_m   <= 1'b0;
            occ_l   <= 1'b0;
            soil    <= 3'd0;
            wet     <= 4'd0;
            timer   <= 12'd0;
            fault   <= 1'b0;
            wdone_q <= 1'b0;
            rdone_q <= 1'b0;
            ddone_q <= 1'b0;
        end else begin
            prev_q  <= act;
            timer   <= timer_nxt;
            fault   <= fault | fault_now;
            wdone_q <= done && (act == PH_WASH);
            rdone_q <= done && (act == PH_RINSE);
            ddone_q <= done && (act == PH_DRY);
            if (UNLOAD && wet == 4'd0 && !any_phase) begin
                occ_m <= 1'b0;
                occ_l <= 1'b0;
                soil  <= 3'd0;
            end else if (LOAD && !UNLOAD && !occupied && !any_phase) begin
                occ_m <= !LOADSIZE;
                occ_l <= LOADSIZE;
                soil  <= SOILIN;
                wet   <= 4'd0;
            end else if (done && occupied) begin
                case (act)
                    PH_WASH: wet <= WET_FULL;
                    PH_RINSE: begin
                        wet  <= WET_FULL;
                        soil <= (soil == 3'd0) ? 3'd0 : soil - 3'd1;
                    end
                    PH_DRY:  wet <= (wet == 4'd0) ? 4'd0 : wet - 4'd1;
                    default: wet <= wet;
                endcase
            end
        end
    end

    assign MEDIUMIn = occ_m;
    assign LARGEIn  = occ_l;
    assign DIRTY    = (soil != 3'd0) && (occ_m | occ_l);
    assign WET      = (wet != 4'd0) && (occ_m | occ_l);
    assign WDONE    = wdone_q;
    assign RDONE    = rdone_q;
    assign DDONE    = ddone_q;
    assign FAULT    = fault;

endmodule
